time_core: RTL and testbench

TIME_CORE -- requirements
Module: time_core

---
 rtl/time_core_pkg.sv | 27 ++
 rtl/time_core_bcd_mmss_counter.sv | 89 ++++++++
 rtl/time_core.sv | 129 ++++++++++++
 tb/tb_time_core.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/time_core_pkg.sv
// Shared types and constants for the stopwatch/timer time core.
// Display source encodings and BCD digit limits live here.
package time_core_pkg;

    typedef enum logic [1:0] {
        DISP_BLANK = 2'b00,
        DISP_LIVE  = 2'b01,
        DISP_LAP   = 2'b10,
        DISP_TIMER = 2'b11
    } disp_sel_e;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } mmss_t;

    localparam mmss_t MMSS_ZERO = '0;
    localparam mmss_t MMSS_ONE  = 16'h0001;

endpackage

// File: rtl/time_core_bcd_mmss_counter.sv
// Four-digit BCD mm:ss counter with up, down, add-minute and clear.
// Down holds at 00:00; up wraps 59:59 to 00:00.
module bcd_mmss_counter
    import time_core_pkg::*;
(
    input  logic  clk,
    input  logic  nrst,
    input  logic  clear,
    input  logic  up,
    input  logic  down,
    input  logic  add_min,
    output mmss_t count
);

    mmss_t next;

    function automatic mmss_t inc_min(input mmss_t c);
        mmss_t r;
        r = c;
        if (c.m0 != MIN_ONES_MAX) begin
            r.m0 = c.m0 + 4'd1;
        end else begin
            r.m0 = 4'd0;
            r.m1 = (c.m1 != MIN_TENS_MAX) ? c.m1 + 4'd1 : 4'd0;
        end
        return r;
    endfunction

    function automatic mmss_t inc_sec(input mmss_t c);
        mmss_t r;
        r = c;
        if (c.s0 != SEC_ONES_MAX) begin
            r.s0 = c.s0 + 4'd1;
        end else begin
            r.s0 = 4'd0;
            if (c.s1 != SEC_TENS_MAX) begin
                r.s1 = c.s1 + 4'd1;
            end else begin
                r.s1 = 4'd0;
                r = inc_min(r);
            end
        end
        return r;
    endfunction

    // Caller guarantees c is non-zero, so the top digit never borrows.
    function automatic mmss_t dec_sec(input mmss_t c);
        mmss_t r;
        r = c;
        if (c.s0 != 4'd0) begin
            r.s0 = c.s0 - 4'd1;
        end else begin
            r.s0 = SEC_ONES_MAX;
            if (c.s1 != 4'd0) begin
                r.s1 = c.s1 - 4'd1;
            end else begin
                r.s1 = SEC_TENS_MAX;
                if (c.m0 != 4'd0) begin
                    r.m0 = c.m0 - 4'd1;
                end else begin
                    r.m0 = MIN_ONES_MAX;
                    r.m1 = c.m1 - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Next-count selection: clear, then up, then down, then add-minute.
    always_comb begin
        next = count;
        if (clear) begin
            next = MMSS_ZERO;
        end else if (up) begin
            next = inc_sec(count);
        end else if (down) begin
            if (count != MMSS_ZERO) next = dec_sec(count);
        end else if (add_min) begin
            next = inc_min(count);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) count <= MMSS_ZERO;
        else       count <= next;
    end

endmodule

// File: rtl/time_core.sv
// Stopwatch/timer core: prescaler, BCD count, lap memory, display mux.
// Laps survive clear; only reset empties them.
module time_core
    import time_core_pkg::*;
#(
    parameter int TICK_DIV  = 10_000_000,
    parameter int LAP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        clear,
    input  logic        enable,
    input  logic        write,
    input  logic        read,
    input  logic        enable_increment,
    input  logic        enable_decrement,
    input  logic        adj,
    input  logic [1:0]  output_select,
    output logic        flag,
    output logic [15:0] disp
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW = $clog2(LAP_DEPTH + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] PTR_MAX = AW'(LAP_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LAP_DEPTH);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(LAP_DEPTH);

    logic [PW-1:0] pre;
    logic          run;
    logic          tick;
    logic          up;
    logic          down;
    mmss_t         count;

    logic [15:0]   mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_idx;
    logic [CW-1:0] lap_count;
    logic [15:0]   lap_out;
    logic [AW-1:0] oldest;
    logic [AW:0]   rd_sum;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_inc;

    assign run  = enable | enable_decrement;
    assign tick = run && (pre == PRE_MAX);
    assign up   = tick && enable;
    assign down = tick && enable_decrement && !enable;

    // Prescaler advances only while a count mode is active.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      pre <= '0;
        else if (clear) pre <= '0;
        else if (run)   pre <= tick ? '0 : pre + PW'(1);
    end

    bcd_mmss_counter u_cnt (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (clear),
        .up      (up),
        .down    (down),
        .add_min (adj & enable_increment),
        .count   (count)
    );

    // Sticky expiry: reaching zero by decrement, or arming at zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            flag <= 1'b0;
        end else if (clear) begin
            flag <= 1'b0;
        end else if (enable_decrement &&
                     (count == MMSS_ZERO ||
                      (down && count == MMSS_ONE))) begin
            flag <= 1'b1;
        end
    end

    // Once full, the write pointer also marks the oldest entry.
    assign oldest  = (lap_count == CNT_MAX) ? wr_ptr : '0;
    assign rd_sum  = {1'b0, oldest} + {1'b0, rd_idx};
    assign rd_addr = (rd_sum >= DEPTH_W) ? AW'(rd_sum - DEPTH_W)
                                         : AW'(rd_sum);
    assign rd_inc  = CW'(rd_idx) + CW'(1);

    // Lap memory: write wins over read; clear blocks both.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_idx    <= '0;
            lap_count <= '0;
            lap_out   <= '0;
        end else if (!clear) begin
            if (write) begin
                mem[wr_ptr] <= count;
                wr_ptr      <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + AW'(1);
                rd_idx      <= '0;
                if (lap_count != CNT_MAX) lap_count <= lap_count + CW'(1);
            end else if (read) begin
                if (lap_count == '0) begin
                    lap_out <= '0;
                end else begin
                    lap_out <= mem[rd_addr];
                    rd_idx  <= (rd_inc >= lap_count) ? '0 : AW'(rd_inc);
                end
            end
        end
    end

    // Registered display source mux.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disp <= '0;
        end else begin
            unique case (disp_sel_e'(output_select))
                DISP_BLANK: disp <= '0;
                DISP_LIVE:  disp <= count;
                DISP_LAP:   disp <= lap_out;
                DISP_TIMER: disp <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_time_core.sv
// Self-checking bench for time_core with a fast prescaler.
// Expected display values are queued at stimulus time and popped on output.
module tb_time_core;
    import time_core_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        enable_increment = 1'b0;
    logic        enable_decrement = 1'b0;
    logic        adj = 1'b0;
    logic [1:0]  output_select = 2'b01;
    logic        flag;
    logic [15:0] disp;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    logic [15:0] lap_exp [5];

    always #5 clk = ~clk;

    time_core #(
        .TICK_DIV  (4),
        .LAP_DEPTH (4)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .clear            (clear),
        .enable           (enable),
        .write            (write),
        .read             (read),
        .enable_increment (enable_increment),
        .enable_decrement (enable_decrement),
        .adj              (adj),
        .output_select    (output_select),
        .flag             (flag),
        .disp             (disp)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 16'(sb.size()), 16'd1);
        end else begin
            e = sb.pop_front();
            check(e.tag, disp, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input string tag, input logic [15:0] v);
        sb_push(tag, v);
        step(1);
        sb_check();
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic adj_pulses(input int n);
        enable_increment = 1'b1;
        for (int i = 0; i < n; i++) begin
            adj = 1'b1;
            step(1);
            adj = 1'b0;
            step(1);
        end
        enable_increment = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lap_exp[0] = 16'h0002;
        lap_exp[1] = 16'h0003;
        lap_exp[2] = 16'h0004;
        lap_exp[3] = 16'h0005;
        lap_exp[4] = 16'h0002;

        // Reset state
        #3;
        sb_push("rst_disp", 16'h0000);
        sb_check();
        check("rst_flag", {15'd0, flag}, 16'd0);
        step(2);
        nrst = 1'b1;
        step(1);

        // Stopwatch run: 12 enabled cycles give 3 ticks
        clear_pulse();
        enable = 1'b1;
        step(12);
        enable = 1'b0;
        show("run3", 16'h0003);
        step(5);
        show("frozen", 16'h0003);
        check("run_flag", {15'd0, flag}, 16'd0);

        // Preload 59:59, minute wrap, then up-count wrap
        clear_pulse();
        adj_pulses(59);
        show("adj59", 16'h5900);
        enable = 1'b1;
        step(236);
        enable = 1'b0;
        show("pre5959", 16'h5959);
        adj_pulses(1);
        show("min_wrap", 16'h0059);
        adj_pulses(59);
        show("back5959", 16'h5959);
        enable = 1'b1;
        step(4);
        enable = 1'b0;
        show("wrap0000", 16'h0000);
        check("wrap_flag", {15'd0, flag}, 16'd0);
        adj = 1'b1;
        step(1);
        adj = 1'b0;
        show("adj_ignored", 16'h0000);

        // Countdown from 02:00
        clear_pulse();
        adj_pulses(2);
        show("tmr0200", 16'h0200);
        enable_decrement = 1'b1;
        step(479);
        check("cd_pre_flag", {15'd0, flag}, 16'd0);
        show("cd0001", 16'h0001);
        check("cd_flag", {15'd0, flag}, 16'd1);
        show("cd_hold", 16'h0000);
        enable_decrement = 1'b0;
        step(10);
        check("flag_sticky", {15'd0, flag}, 16'd1);
        clear_pulse();
        check("flag_clear", {15'd0, flag}, 16'd0);
        enable_decrement = 1'b1;
        step(1);
        check("flag_arm0", {15'd0, flag}, 16'd1);
        enable_decrement = 1'b0;
        clear_pulse();

        // Lap memory
        output_select = 2'b10;
        read = 1'b1;
        step(1);
        read = 1'b0;
        show("lap_empty", 16'h0000);
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1;
            step(4);
            enable = 1'b0;
            write = 1'b1;
            step(1);
            write = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            read = 1'b1;
            step(1);
            read = 1'b0;
            show($sformatf("lap%0d", i), lap_exp[i]);
        end
        output_select = 2'b01;
        show("sel_live", 16'h0005);
        output_select = 2'b00;
        show("sel_blank", 16'h0000);
        output_select = 2'b11;
        show("sel_timer", 16'h0005);
        output_select = 2'b10;
        read = 1'b1;
        write = 1'b1;
        step(1);
        read = 1'b0;
        write = 1'b0;
        show("rw_write_only", 16'h0002);
        read = 1'b1;
        step(1);
        read = 1'b0;
        show("rw_oldest", 16'h0003);

        // Reset mid-countdown at 00:30
        output_select = 2'b01;
        clear_pulse();
        adj_pulses(1);
        enable_decrement = 1'b1;
        step(120);
        enable_decrement = 1'b0;
        show("cd0030", 16'h0030);
        check("cd30_flag", {15'd0, flag}, 16'd0);
        enable_decrement = 1'b1;
        step(2);
        #2;
        nrst = 1'b0;
        #1;
        sb_push("async_disp", 16'h0000);
        sb_check();
        check("async_flag", {15'd0, flag}, 16'd0);
        enable_decrement = 1'b0;
        step(2);
        nrst = 1'b1;
        step(1);
        output_select = 2'b10;
        read = 1'b1;
        step(1);
        read = 1'b0;
        show("rst_lap", 16'h0000);
        output_select = 2'b01;
        show("rst_live", 16'h0000);
        check("rst_flag2", {15'd0, flag}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
